// File: rtl/fuzzy_inference_engine.sv
// Two-input (error, error-rate) Mamdani-style fuzzy controller with singleton
// outputs: fuzzify, evaluate 9 rules serially, then defuzzify by restoring division.
module fuzzy_inference_engine #(
  parameter int          E_SHIFT   = 10,
  parameter logic [11:0] DUTY_INIT = 12'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] v1,
  input  logic [11:0] v2,
  output logic        busy,
  output logic        done,
  output logic [11:0] duty
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] FUZZ = 3'd1;
  localparam logic [2:0] RULE = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]         state;
  logic signed [12:0] e_r;
  logic signed [12:0] de_r;
  logic signed [12:0] e_prev;
  logic [8:0]         mu_e  [3];
  logic [8:0]         mu_de [3];
  logic [24:0]        num;
  logic [11:0]        den;
  logic [3:0]         rule_idx;
  logic [3:0]         bit_cnt;
  logic [12:0]        rem;
  logic [11:0]        dq;

  // Membership magnitude: |x| scaled so that 2^E_SHIFT codes maps to 256.
  function automatic logic [8:0] fuzz_mag(input logic signed [12:0] x);
    logic [12:0] a;
    a = x[12] ? 13'(-x) : 13'(x);
    a = a >> (E_SHIFT - 8);
    if (a > 13'd256) return 9'd256;
    return a[8:0];
  endfunction

  // ------------------------------------------------------------------
  // Error sampling
  // ------------------------------------------------------------------
  logic signed [12:0] e_in;
  logic signed [13:0] de_wide;
  logic signed [12:0] de_sat;

  always_comb begin
    e_in    = $signed({1'b0, v1}) - $signed({1'b0, v2});
    de_wide = {e_in[12], e_in} - {e_prev[12], e_prev};
    de_sat  = de_wide[12:0];
    if (de_wide > 14'sd4095)       de_sat = 13'sd4095;
    else if (de_wide < -14'sd4095) de_sat = -13'sd4095;
  end

  // ------------------------------------------------------------------
  // Rule evaluation: rule_idx = 3*a + b, singleton index a+b
  // ------------------------------------------------------------------
  logic [1:0]  a_idx;
  logic [1:0]  b_idx;
  logic [8:0]  w;
  logic [11:0] s_val;
  logic [20:0] prod;
  logic [24:0] num_next;
  logic [11:0] den_next;

  always_comb begin
    a_idx = 2'd0;
    b_idx = 2'd0;
    case (rule_idx)
      4'd0: begin a_idx = 2'd0; b_idx = 2'd0; end
      4'd1: begin a_idx = 2'd0; b_idx = 2'd1; end
      4'd2: begin a_idx = 2'd0; b_idx = 2'd2; end
      4'd3: begin a_idx = 2'd1; b_idx = 2'd0; end
      4'd4: begin a_idx = 2'd1; b_idx = 2'd1; end
      4'd5: begin a_idx = 2'd1; b_idx = 2'd2; end
      4'd6: begin a_idx = 2'd2; b_idx = 2'd0; end
      4'd7: begin a_idx = 2'd2; b_idx = 2'd1; end
      4'd8: begin a_idx = 2'd2; b_idx = 2'd2; end
      default: begin a_idx = 2'd0; b_idx = 2'd0; end
    endcase
    w = (mu_e[a_idx] < mu_de[b_idx]) ? mu_e[a_idx] : mu_de[b_idx];
    case (3'(a_idx) + 3'(b_idx))
      3'd0:    s_val = 12'd0;
      3'd1:    s_val = 12'd1024;
      3'd2:    s_val = 12'd2048;
      3'd3:    s_val = 12'd3072;
      default: s_val = 12'd4095;
    endcase
    prod     = 21'(w) * 21'(s_val);
    num_next = num + 25'(prod);
    den_next = den + 12'(w);
  end

  // ------------------------------------------------------------------
  // Restoring division step: quotient bits shift into dq as dividend bits leave
  // ------------------------------------------------------------------
  logic [13:0] trial;
  logic        ge;

  always_comb begin
    trial = {rem, dq[11]};
    ge    = (trial >= {2'b00, den});
  end

  // ------------------------------------------------------------------
  // Control and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      duty     <= DUTY_INIT;
      e_r      <= '0;
      de_r     <= '0;
      e_prev   <= '0;
      num      <= '0;
      den      <= '0;
      rule_idx <= '0;
      bit_cnt  <= '0;
      rem      <= '0;
      dq       <= '0;
      for (int i = 0; i < 3; i++) begin
        mu_e[i]  <= '0;
        mu_de[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            e_r   <= e_in;
            de_r  <= de_sat;
            state <= FUZZ;
          end
        end
        FUZZ: begin
          e_prev   <= e_r;
          mu_e[0]  <= e_r[12] ? fuzz_mag(e_r) : 9'd0;
          mu_e[1]  <= 9'd256 - fuzz_mag(e_r);
          mu_e[2]  <= (!e_r[12] && e_r != 13'sd0) ? fuzz_mag(e_r) : 9'd0;
          mu_de[0] <= de_r[12] ? fuzz_mag(de_r) : 9'd0;
          mu_de[1] <= 9'd256 - fuzz_mag(de_r);
          mu_de[2] <= (!de_r[12] && de_r != 13'sd0) ? fuzz_mag(de_r) : 9'd0;
          num      <= '0;
          den      <= '0;
          rule_idx <= '0;
          state    <= RULE;
        end
        RULE: begin
          num <= num_next;
          den <= den_next;
          if (rule_idx == 4'd8) begin
            rule_idx <= '0;
            // Weighted average never exceeds 4095, so num[24:12] < den here.
            rem      <= num_next[24:12];
            dq       <= num_next[11:0];
            bit_cnt  <= '0;
            state    <= DIV;
          end else begin
            rule_idx <= rule_idx + 4'd1;
          end
        end
        DIV: begin
          rem <= ge ? 13'(trial - {2'b00, den}) : trial[12:0];
          dq  <= {dq[10:0], ge};
          if (bit_cnt == 4'd11) begin
            bit_cnt <= '0;
            state   <= DONE;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        DONE: begin
          done <= 1'b1;
          if (den != 12'd0) duty <= dq;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fuzzy_inference_engine.sv
// Directed bench for fuzzy_inference_engine: a cycle model of the handshake plus
// an arithmetic reference for duty, with expected results queued at each accepted start.
module tb_fuzzy_inference_engine;

  localparam int          E_SHIFT   = 10;
  localparam logic [11:0] DUTY_INIT = 12'd300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] v1;
  logic [11:0] v2;
  logic        busy;
  logic        done;
  logic [11:0] duty;

  always #5 clk = ~clk;

  fuzzy_inference_engine #(.E_SHIFT(E_SHIFT), .DUTY_INIT(DUTY_INIT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .v1   (v1),
    .v2   (v2),
    .busy (busy),
    .done (done),
    .duty (duty)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [12:0] exp_q[$];
  int          phase    = 0;
  int          ep_model = 0;
  logic [11:0] duty_model = DUTY_INIT;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          done_cnt = 0;
  int          d0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mu_of(input int x, input int k);
    int m;
    m = (x < 0 ? -x : x) >> (E_SHIFT - 8);
    if (m > 256) m = 256;
    case (k)
      0:       return (x < 0) ? m : 0;
      1:       return 256 - m;
      default: return (x > 0) ? m : 0;
    endcase
  endfunction

  // Bit 12 set means den==0: duty is expected to hold.
  function automatic logic [12:0] model(input int a1, input int a2, input int ep, output int e_o);
    int e, de, num, den, w, wa, wb;
    int s[5];
    s = '{0, 1024, 2048, 3072, 4095};
    e  = a1 - a2;
    de = e - ep;
    if (de > 4095)  de = 4095;
    if (de < -4095) de = -4095;
    e_o = e;
    num = 0;
    den = 0;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        wa = mu_of(e, a);
        wb = mu_of(de, b);
        w  = (wa < wb) ? wa : wb;
        num += w * s[a + b];
        den += w;
      end
    end
    if (den == 0) return 13'h1000;
    return 13'(num / den);
  endfunction

  task automatic tick();
    bit          exp_done;
    logic [12:0] r;
    int          e_tmp;
    exp_done = (phase == 23) && rst_n;
    if (!rst_n) begin
      phase = 0;
      exp_q.delete();
      ep_model = 0;
      duty_model = DUTY_INIT;
    end else if (phase == 0) begin
      if (start) begin
        exp_q.push_back(model(int'(v1), int'(v2), ep_model, e_tmp));
        ep_model = e_tmp;
        phase = 1;
        acc_cyc = cyc;
      end
    end else if (phase == 23) begin
      phase = 0;
    end else begin
      phase++;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("done", int'(done), int'(exp_done));
    chk("busy", int'(busy), int'(phase != 0));
    if (done) begin
      done_cnt++;
      if (exp_q.size() != 1) begin
        chk("queue_depth", exp_q.size(), 1);
      end else begin
        r = exp_q.pop_front();
        if (!r[12]) duty_model = r[11:0];
        chk("latency", cyc - (acc_cyc + 1), 23);
      end
    end
    chk("duty", int'(duty), int'(duty_model));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((phase != 0 || exp_q.size() != 0) && k < 60) begin
      tick();
      k++;
    end
    chk("drain_timeout", int'(phase != 0 || exp_q.size() != 0), 0);
  endtask

  task automatic run_one(input logic [11:0] a, input logic [11:0] b);
    v1 = a;
    v2 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    v1 = 12'($urandom_range(0, 4095));
    v2 = 12'($urandom_range(0, 4095));
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    v1 = '0;
    v2 = '0;
    repeat (3) tick();
    chk("reset_duty", int'(duty), int'(DUTY_INIT));
    rst_n = 1'b1;
    tick();

    run_one(12'd2000, 12'd2000);
    chk("zz_only", int'(duty), 2048);
    run_one(12'd3000, 12'd1000);
    chk("pp_only", int'(duty), 4095);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_one(12'd1000, 12'd1512);
    chk("nz_mix", int'(duty), 1024);

    // Starts while busy are ignored.
    d0 = done_cnt;
    v1 = 12'd2200;
    v2 = 12'd1900;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    chk("one_done_per_start", done_cnt - d0, 1);

    // Start held high: back-to-back inferences.
    d0 = done_cnt;
    v1 = 12'd2500;
    v2 = 12'd1800;
    start = 1'b1;
    repeat (100) tick();
    chk("held_start_dones", done_cnt - d0, 4);
    start = 1'b0;
    drain();

    // Reset during DIV aborts the inference.
    v1 = 12'd3100;
    v2 = 12'd2900;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_duty", int'(duty), int'(DUTY_INIT));
    d0 = done_cnt;
    repeat (30) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_one(12'd1000, 12'd1512);
    chk("post_abort", int'(duty), 1024);

    // Saturation extremes and random operating points.
    run_one(12'd4095, 12'd0);
    run_one(12'd0, 12'd4095);
    chk("full_neg", int'(duty), 0);
    for (int i = 0; i < 8; i++) begin
      run_one(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzzy_inference_engine.md
FUZZY_INFERENCE_ENGINE -- requirements
Module: fuzzy_inference_engine

Sits between the ADC controller outputs (v1 setpoint, v2 feedback) and the PWM stage, producing the pulse-width word.

Interface
REQ-001 SHALL have parameter E_SHIFT, default 10: membership half-width is 2^E_SHIFT ADC codes; legal range 8..12.
REQ-002 SHALL have parameter DUTY_INIT, default 0: duty value after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request one inference; sampled only in IDLE.
REQ-006 SHALL have port v1, input, 12 bits: setpoint, unsigned ADC code.
REQ-007 SHALL have port v2, input, 12 bits: measured value, unsigned ADC code.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse; duty is valid from this cycle on.
REQ-010 SHALL have port duty, output, 12 bits: registered pulse-width word, held between updates.

Function
REQ-011 SHALL use FSM states IDLE, FUZZ, RULE, DIV, DONE, with transitions: IDLE->FUZZ on start=1; FUZZ->RULE; RULE->DIV after 9 cycles; DIV->DONE after 12 cycles; DONE->IDLE unconditionally.
REQ-012 SHALL, on the IDLE edge that samples start, register e = v1 - v2 (13-bit signed) and de = e - e_prev, saturated to [-4095, +4095].
REQ-013 SHALL set e_prev to the current e in FUZZ.
REQ-014 SHALL fuzzify each of e and de in FUZZ with m = min(|x| >> (E_SHIFT-8), 256): Z = 256 - m; P = m if x > 0, else 0; N = m if x < 0, else 0.
REQ-015 SHALL assign set indices N=0, Z=1, P=2; rule (a,b) has strength w = min(mu_e[a], mu_de[b]) and singleton S[a+b], where S = {0, 1024, 2048, 3072, 4095}.
REQ-016 SHALL evaluate one rule per RULE cycle in order (a,b) = (0,0), (0,1) ... (2,2), accumulating num += w*S (25-bit unsigned) and den += w (12-bit unsigned); both SHALL clear in FUZZ.
REQ-017 SHALL compute duty = num / den in DIV by restoring division, one quotient bit per cycle, MSB first, 12 bits, truncating.
REQ-018 SHALL, in DONE, load the quotient into duty and drive done=1; if den == 0, duty SHALL keep its previous value while done still pulses.
REQ-019 SHALL ignore start in every state except IDLE; start held high SHALL restart in the IDLE cycle following DONE.
REQ-020 SHALL assert done exactly 23 cycles after the start-sampling edge, with duty updating on the same edge; busy SHALL be high from the following edge through DONE.
REQ-021 SHALL ignore changes on v1/v2 after sampling until the next accepted start.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, force state=IDLE, busy=0, done=0, duty=DUTY_INIT, e_prev=0, num=0, den=0 and clear the rule and bit counters.
REQ-023 SHALL, on reset mid-operation, abort the operation: no done pulse, duty=DUTY_INIT, and the next start is processed normally.

Verification
REQ-024 SHALL cover: after reset, v1=v2=2000, start pulse -> done at +23 cycles, duty=2048 (only ZZ active, w=256).
REQ-025 SHALL cover: after reset, v1=1000, v2=1512, start -> e=de=-512, N=Z=128, num=524288, den=512, duty=1024.
REQ-026 SHALL cover: after scenario REQ-024, v1=3000, v2=1000, start -> e=de=2000, only PP active, duty=4095.
REQ-027 SHALL cover: start held high for 100 cycles -> done pulses every 24 cycles; busy low only in the IDLE cycles.
REQ-028 SHALL cover: rst_n=0 for one cycle during DIV -> busy=0 next cycle, no done pulse, duty=DUTY_INIT; the following start -> normal result.
REQ-029 SHALL cover: a start pulse while busy -> ignored, with only one done per accepted start.
